// File: rtl/bcd_timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// bcd_timer_ctrl_if
// Groups the user command pulses, the counter feedback bus and the counter
// control outputs of the BCD timer controller into one bundle.
//   i_start / i_stop / i_reset : single-cycle command pulses
//   i_mode                     : 1 = stopwatch, 0 = countdown
//   i_preset[15:0]             : countdown start value, 4 BCD digits
//   i_cnt_val[15:0]            : current BCD value of the counter
//   o_cnt_clr, o_cnt_load[15:0], o_cnt_load_en, o_cnt_en, o_cnt_dir
//                              : counter control
//   o_running, o_done, o_err   : status
// Signal prefixes are from the controller's point of view.
// Modports: master = whoever drives the commands, slave = the controller.
// ---------------------------------------------------------------------------
interface bcd_timer_ctrl_if;
  logic        i_start;
  logic        i_stop;
  logic        i_reset;
  logic        i_mode;
  logic [15:0] i_preset;
  logic [15:0] i_cnt_val;
  logic        o_cnt_clr;
  logic [15:0] o_cnt_load;
  logic        o_cnt_load_en;
  logic        o_cnt_en;
  logic        o_cnt_dir;
  logic        o_running;
  logic        o_done;
  logic        o_err;

  modport master (
    output i_start, i_stop, i_reset, i_mode, i_preset, i_cnt_val,
    input  o_cnt_clr, o_cnt_load, o_cnt_load_en, o_cnt_en, o_cnt_dir,
           o_running, o_done, o_err
  );

  modport slave (
    input  i_start, i_stop, i_reset, i_mode, i_preset, i_cnt_val,
    output o_cnt_clr, o_cnt_load, o_cnt_load_en, o_cnt_en, o_cnt_dir,
           o_running, o_done, o_err
  );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_timer_ctrl
// Sequencing controller that turns a 4-digit BCD up/down counter into a
// countdown timer (mode 0, from a preset down to 0000) or a stopwatch
// (mode 1, from 0000 up to 9999). It generates clear/load/enable/direction
// for the counter, divides the clock into count ticks and stops the count at
// the terminal value so the counter never wraps.
// Ports:
//   i_clk    : system clock, rising edge
//   i_clr_n  : asynchronous active-low reset
//   io_bus   : bcd_timer_ctrl_if.slave (commands, counter value, counter
//              control and status outputs; all outputs are registered)
// Parameters:
//   TICK_DIV : clock cycles per count tick (>= 2)
//   PS_W     : prescaler width, 2**PS_W >= TICK_DIV
// ---------------------------------------------------------------------------
module bcd_timer_ctrl #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned PS_W     = 2
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  bcd_timer_ctrl_if.slave  io_bus
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  localparam logic [PS_W-1:0] LP_PS_LAST = PS_W'(TICK_DIV - 1);

  state_t          r_state;
  logic [PS_W-1:0] r_ps;
  logic            r_mode;
  logic            r_cnt_clr;
  logic [15:0]     r_cnt_load;
  logic            r_cnt_load_en;
  logic            r_cnt_en;
  logic            r_running;
  logic            r_done;
  logic            r_err;

  logic            w_preset_ok;
  logic            w_terminal;

  // A countdown preset is usable only if every nibble is a decimal digit and
  // the value is not already at the terminal count.
  assign w_preset_ok = (io_bus.i_preset[15:12] <= 4'd9) &&
                       (io_bus.i_preset[11:8]  <= 4'd9) &&
                       (io_bus.i_preset[7:4]   <= 4'd9) &&
                       (io_bus.i_preset[3:0]   <= 4'd9) &&
                       (io_bus.i_preset != 16'h0000);

  assign w_terminal = r_mode ? (io_bus.i_cnt_val == 16'h9999)
                             : (io_bus.i_cnt_val == 16'h0000);

  // Main sequencer. Clear, load, enable and error are one-cycle pulses that
  // default low every cycle. RESET wins over everything, then STOP, then
  // START. The terminal check is skipped while an enable pulse is out,
  // because the counter value seen in that cycle is still the old one.
  // STOP in RUN freezes the prescaler, so a resume continues the partial
  // tick instead of restarting it.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state       <= ST_INIT;
      r_ps          <= '0;
      r_mode        <= 1'b0;
      r_cnt_clr     <= 1'b1;
      r_cnt_load    <= 16'h0000;
      r_cnt_load_en <= 1'b0;
      r_cnt_en      <= 1'b0;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_cnt_clr     <= 1'b0;
      r_cnt_load_en <= 1'b0;
      r_cnt_en      <= 1'b0;
      r_err         <= 1'b0;
      if (io_bus.i_reset) begin
        r_cnt_clr <= 1'b1;
        r_ps      <= '0;
        r_state   <= ST_IDLE;
        r_running <= 1'b0;
        r_done    <= 1'b0;
      end else begin
        case (r_state)
          ST_INIT: begin
            r_state <= ST_IDLE;
          end
          ST_IDLE, ST_DONE: begin
            if (!io_bus.i_stop && io_bus.i_start) begin
              if (io_bus.i_mode) begin
                r_mode    <= 1'b1;
                r_cnt_clr <= 1'b1;
                r_state   <= ST_ARM;
                r_done    <= 1'b0;
              end else if (w_preset_ok) begin
                r_mode        <= 1'b0;
                r_cnt_load    <= io_bus.i_preset;
                r_cnt_load_en <= 1'b1;
                r_state       <= ST_ARM;
                r_done        <= 1'b0;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          ST_ARM: begin
            r_ps      <= '0;
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
          ST_RUN: begin
            if (io_bus.i_stop) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end else if (!r_cnt_en && w_terminal) begin
              r_state   <= ST_DONE;
              r_ps      <= '0;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end else if (r_ps == LP_PS_LAST) begin
              r_ps     <= '0;
              r_cnt_en <= 1'b1;
            end else begin
              r_ps <= r_ps + 1'b1;
            end
          end
          ST_PAUSE: begin
            if (!io_bus.i_stop && io_bus.i_start) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign io_bus.o_cnt_clr     = r_cnt_clr;
  assign io_bus.o_cnt_load    = r_cnt_load;
  assign io_bus.o_cnt_load_en = r_cnt_load_en;
  assign io_bus.o_cnt_en      = r_cnt_en;
  assign io_bus.o_cnt_dir     = r_mode;
  assign io_bus.o_running     = r_running;
  assign io_bus.o_done        = r_done;
  assign io_bus.o_err         = r_err;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_timer_ctrl
// Directed bench for bcd_timer_ctrl with TICK_DIV = 4. A behavioural BCD
// counter closes the loop on the counter bus; it can also be preloaded
// directly to emulate forcing the counter value.
// ---------------------------------------------------------------------------
module tb_bcd_timer_ctrl;

  logic clk = 1'b0;
  logic clrN;
  int   checks = 0;
  int   errors = 0;
  int   enCount = 0;
  logic [15:0] modelVal;
  logic        preloadReq = 1'b0;
  logic [15:0] preloadValue = 16'h0000;

  bcd_timer_ctrl_if bus ();

  bcd_timer_ctrl #(.TICK_DIV(4), .PS_W(2)) dut (
    .i_clk   (clk),
    .i_clr_n (clrN),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  // BCD increment / decrement with per-digit carry and borrow.
  function automatic logic [15:0] bcdInc(input logic [15:0] v);
    logic [15:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin r[i*4 +: 4] = r[i*4 +: 4] + 4'd1; c = 1'b0; end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcdDec(input logic [15:0] v);
    logic [15:0] r;
    logic b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
        else begin r[i*4 +: 4] = r[i*4 +: 4] - 4'd1; b = 1'b0; end
      end
    end
    return r;
  endfunction

  // Behavioural counter driven by the controller outputs.
  always @(posedge clk or negedge clrN) begin
    if (!clrN) modelVal <= 16'h0000;
    else if (preloadReq) modelVal <= preloadValue;
    else if (bus.o_cnt_clr) modelVal <= 16'h0000;
    else if (bus.o_cnt_load_en) modelVal <= bus.o_cnt_load;
    else if (bus.o_cnt_en) modelVal <= bus.o_cnt_dir ? bcdInc(modelVal) : bcdDec(modelVal);
  end

  assign bus.i_cnt_val = modelVal;

  // Enable pulses are counted mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.o_cnt_en === 1'b1) enCount = enCount + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    clrN = 1'b0;
    tick(2);
    checks++; if (bus.o_cnt_clr !== 1'b1) begin errors++; $display("[TB] FAIL rst_clr got %0b want 1", bus.o_cnt_clr); end
    checks++; if (bus.o_cnt_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_en got %0b want 0", bus.o_cnt_en); end
    checks++; if (bus.o_cnt_load_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_load_en got %0b want 0", bus.o_cnt_load_en); end
    checks++; if (bus.o_cnt_load !== 16'h0000) begin errors++; $display("[TB] FAIL rst_load got %h want 0000", bus.o_cnt_load); end
    checks++; if ({bus.o_running, bus.o_done, bus.o_err, bus.o_cnt_dir} !== 4'b0000) begin errors++; $display("[TB] FAIL rst_status got %b want 0000", {bus.o_running, bus.o_done, bus.o_err, bus.o_cnt_dir}); end
    @(negedge clk);
    clrN = 1'b1;
    #1;
    checks++; if (bus.o_cnt_clr !== 1'b1) begin errors++; $display("[TB] FAIL init_clr got %0b want 1", bus.o_cnt_clr); end
    tick(1);
    checks++; if (bus.o_cnt_clr !== 1'b0) begin errors++; $display("[TB] FAIL idle_clr got %0b want 0", bus.o_cnt_clr); end
    tick(2);
    checks++; if ({bus.o_cnt_clr, bus.o_cnt_load_en, bus.o_cnt_en, bus.o_running, bus.o_done, bus.o_err} !== 6'b0) begin errors++; $display("[TB] FAIL idle_outputs got %b want 000000", {bus.o_cnt_clr, bus.o_cnt_load_en, bus.o_cnt_en, bus.o_running, bus.o_done, bus.o_err}); end
  endtask

  task automatic test_countdown();
    int base;
    bus.i_mode = 1'b0;
    bus.i_preset = 16'h0003;
    bus.i_start = 1'b1;
    tick(1);
    bus.i_start = 1'b0;
    checks++; if (bus.o_cnt_load_en !== 1'b1) begin errors++; $display("[TB] FAIL cd_load_en got %0b want 1", bus.o_cnt_load_en); end
    checks++; if (bus.o_cnt_load !== 16'h0003) begin errors++; $display("[TB] FAIL cd_load got %h want 0003", bus.o_cnt_load); end
    checks++; if (bus.o_cnt_dir !== 1'b0) begin errors++; $display("[TB] FAIL cd_dir got %0b want 0", bus.o_cnt_dir); end
    tick(1);
    base = enCount;
    checks++; if (bus.o_running !== 1'b1) begin errors++; $display("[TB] FAIL cd_running got %0b want 1", bus.o_running); end
    checks++; if (bus.o_cnt_load_en !== 1'b0) begin errors++; $display("[TB] FAIL cd_load_pulse got %0b want 0", bus.o_cnt_load_en); end
    checks++; if (modelVal !== 16'h0003) begin errors++; $display("[TB] FAIL cd_loaded got %h want 0003", modelVal); end
    tick(3);
    checks++; if (bus.o_cnt_en !== 1'b0) begin errors++; $display("[TB] FAIL cd_en_early got %0b want 0", bus.o_cnt_en); end
    tick(1);
    checks++; if (bus.o_cnt_en !== 1'b1) begin errors++; $display("[TB] FAIL cd_en_first got %0b want 1", bus.o_cnt_en); end
    tick(1);
    checks++; if (bus.o_cnt_en !== 1'b0) begin errors++; $display("[TB] FAIL cd_en_width got %0b want 0", bus.o_cnt_en); end
    tick(7);
    checks++; if (bus.o_cnt_en !== 1'b1 || modelVal !== 16'h0001) begin errors++; $display("[TB] FAIL cd_third_tick got en=%0b val=%h want en=1 val=0001", bus.o_cnt_en, modelVal); end
    tick(1);
    checks++; if (modelVal !== 16'h0000 || bus.o_done !== 1'b0) begin errors++; $display("[TB] FAIL cd_zero got val=%h done=%0b want val=0000 done=0", modelVal, bus.o_done); end
    tick(1);
    checks++; if (bus.o_done !== 1'b1 || bus.o_running !== 1'b0) begin errors++; $display("[TB] FAIL cd_done got done=%0b running=%0b want 1/0", bus.o_done, bus.o_running); end
    tick(8);
    checks++; if (enCount - base !== 3) begin errors++; $display("[TB] FAIL cd_en_count got %0d want 3", enCount - base); end
    checks++; if (modelVal !== 16'h0000 || bus.o_done !== 1'b1) begin errors++; $display("[TB] FAIL cd_hold got val=%h done=%0b want 0000/1", modelVal, bus.o_done); end
  endtask

  task automatic test_stopwatch();
    int base;
    int n;
    bus.i_mode = 1'b1;
    bus.i_start = 1'b1;
    tick(1);
    bus.i_start = 1'b0;
    bus.i_mode = 1'b0;
    checks++; if (bus.o_cnt_clr !== 1'b1 || bus.o_cnt_load_en !== 1'b0) begin errors++; $display("[TB] FAIL sw_clr got clr=%0b load_en=%0b want 1/0", bus.o_cnt_clr, bus.o_cnt_load_en); end
    checks++; if (bus.o_cnt_dir !== 1'b1 || bus.o_done !== 1'b0) begin errors++; $display("[TB] FAIL sw_dir got dir=%0b done=%0b want 1/0", bus.o_cnt_dir, bus.o_done); end
    tick(1);
    checks++; if (bus.o_running !== 1'b1 || modelVal !== 16'h0000) begin errors++; $display("[TB] FAIL sw_run got running=%0b val=%h want 1/0000", bus.o_running, modelVal); end
    preloadValue = 16'h9997;
    preloadReq = 1'b1;
    tick(1);
    preloadReq = 1'b0;
    base = enCount;
    n = 0;
    while (bus.o_done !== 1'b1 && n < 30) begin
      tick(1);
      n++;
    end
    checks++; if (bus.o_done !== 1'b1) begin errors++; $display("[TB] FAIL sw_done_timeout got done=%0b want 1", bus.o_done); end
    checks++; if (enCount - base !== 2 || modelVal !== 16'h9999) begin errors++; $display("[TB] FAIL sw_final got en=%0d val=%h want 2/9999", enCount - base, modelVal); end
    tick(8);
    checks++; if (enCount - base !== 2 || modelVal !== 16'h9999) begin errors++; $display("[TB] FAIL sw_nowrap got en=%0d val=%h want 2/9999", enCount - base, modelVal); end
  endtask

  task automatic test_pause_resume();
    int base;
    int paused;
    bus.i_mode = 1'b0;
    bus.i_preset = 16'h0020;
    bus.i_start = 1'b1;
    tick(1);
    bus.i_start = 1'b0;
    checks++; if (bus.o_cnt_load_en !== 1'b1 || bus.o_cnt_load !== 16'h0020 || bus.o_cnt_dir !== 1'b0) begin errors++; $display("[TB] FAIL pr_load got en=%0b load=%h dir=%0b want 1/0020/0", bus.o_cnt_load_en, bus.o_cnt_load, bus.o_cnt_dir); end
    tick(1);
    base = enCount;
    tick(12);
    checks++; if (bus.o_cnt_en !== 1'b1 || enCount - base !== 2 || modelVal !== 16'h0018) begin errors++; $display("[TB] FAIL pr_third got en=%0b cnt=%0d val=%h want 1/2/0018", bus.o_cnt_en, enCount - base, modelVal); end
    tick(2);
    bus.i_stop = 1'b1;
    tick(1);
    bus.i_stop = 1'b0;
    paused = enCount;
    checks++; if (bus.o_running !== 1'b0 || bus.o_cnt_en !== 1'b0 || modelVal !== 16'h0017) begin errors++; $display("[TB] FAIL pr_pause got running=%0b en=%0b val=%h want 0/0/0017", bus.o_running, bus.o_cnt_en, modelVal); end
    checks++; if (paused - base !== 3) begin errors++; $display("[TB] FAIL pr_count_before got %0d want 3", paused - base); end
    tick(10);
    checks++; if (enCount !== paused || modelVal !== 16'h0017 || bus.o_running !== 1'b0) begin errors++; $display("[TB] FAIL pr_hold got en=%0d val=%h running=%0b want 0/0017/0", enCount - paused, modelVal, bus.o_running); end
    bus.i_start = 1'b1;
    tick(1);
    bus.i_start = 1'b0;
    checks++; if (bus.o_running !== 1'b1 || bus.o_cnt_en !== 1'b0) begin errors++; $display("[TB] FAIL pr_resume got running=%0b en=%0b want 1/0", bus.o_running, bus.o_cnt_en); end
    tick(1);
    checks++; if (bus.o_cnt_en !== 1'b0) begin errors++; $display("[TB] FAIL pr_resume_early got %0b want 0", bus.o_cnt_en); end
    tick(1);
    checks++; if (bus.o_cnt_en !== 1'b1 || modelVal !== 16'h0017) begin errors++; $display("[TB] FAIL pr_resume_tick got en=%0b val=%h want 1/0017", bus.o_cnt_en, modelVal); end
  endtask

  task automatic test_reset_precedence();
    int base;
    bus.i_reset = 1'b1;
    bus.i_start = 1'b1;
    bus.i_stop = 1'b1;
    tick(1);
    bus.i_reset = 1'b0;
    bus.i_start = 1'b0;
    bus.i_stop = 1'b0;
    checks++; if (bus.o_cnt_clr !== 1'b1 || bus.o_running !== 1'b0 || bus.o_cnt_en !== 1'b0 || bus.o_done !== 1'b0) begin errors++; $display("[TB] FAIL rp_reset got clr=%0b run=%0b en=%0b done=%0b want 1/0/0/0", bus.o_cnt_clr, bus.o_running, bus.o_cnt_en, bus.o_done); end
    tick(1);
    base = enCount;
    checks++; if (bus.o_cnt_clr !== 1'b0 || modelVal !== 16'h0000) begin errors++; $display("[TB] FAIL rp_clr_pulse got clr=%0b val=%h want 0/0000", bus.o_cnt_clr, modelVal); end
    tick(10);
    checks++; if (enCount !== base || bus.o_running !== 1'b0 || modelVal !== 16'h0000 || bus.o_err !== 1'b0) begin errors++; $display("[TB] FAIL rp_idle got en=%0d run=%0b val=%h err=%0b want 0/0/0000/0", enCount - base, bus.o_running, modelVal, bus.o_err); end
  endtask

  task automatic test_reject();
    bus.i_mode = 1'b0;
    bus.i_preset = 16'h00A5;
    bus.i_start = 1'b1;
    tick(1);
    bus.i_start = 1'b0;
    checks++; if (bus.o_err !== 1'b1 || bus.o_cnt_load_en !== 1'b0 || bus.o_cnt_clr !== 1'b0 || bus.o_running !== 1'b0) begin errors++; $display("[TB] FAIL rej_a5 got err=%0b load_en=%0b clr=%0b run=%0b want 1/0/0/0", bus.o_err, bus.o_cnt_load_en, bus.o_cnt_clr, bus.o_running); end
    tick(1);
    checks++; if (bus.o_err !== 1'b0 || bus.o_running !== 1'b0 || bus.o_cnt_load_en !== 1'b0) begin errors++; $display("[TB] FAIL rej_a5_after got err=%0b run=%0b load_en=%0b want 0/0/0", bus.o_err, bus.o_running, bus.o_cnt_load_en); end
    bus.i_preset = 16'h0000;
    bus.i_start = 1'b1;
    tick(1);
    bus.i_start = 1'b0;
    checks++; if (bus.o_err !== 1'b1 || bus.o_cnt_load_en !== 1'b0) begin errors++; $display("[TB] FAIL rej_zero got err=%0b load_en=%0b want 1/0", bus.o_err, bus.o_cnt_load_en); end
    tick(1);
    checks++; if (bus.o_err !== 1'b0 || bus.o_running !== 1'b0 || modelVal !== 16'h0000) begin errors++; $display("[TB] FAIL rej_zero_after got err=%0b run=%0b val=%h want 0/0/0000", bus.o_err, bus.o_running, modelVal); end
    bus.i_preset = 16'h9999;
    bus.i_start = 1'b1;
    tick(1);
    bus.i_start = 1'b0;
    checks++; if (bus.o_err !== 1'b0 || bus.o_cnt_load_en !== 1'b1 || bus.o_cnt_load !== 16'h9999) begin errors++; $display("[TB] FAIL rej_accept_max got err=%0b load_en=%0b load=%h want 0/1/9999", bus.o_err, bus.o_cnt_load_en, bus.o_cnt_load); end
    bus.i_reset = 1'b1;
    tick(1);
    bus.i_reset = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got running want finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.i_start = 1'b0;
    bus.i_stop = 1'b0;
    bus.i_reset = 1'b0;
    bus.i_mode = 1'b0;
    bus.i_preset = 16'h0000;
    test_reset();
    test_countdown();
    test_stopwatch();
    test_pause_resume();
    test_reset_precedence();
    test_reject();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
Sequencing controller for the 4-digit BCD up/down counter; turns the counter into a countdown timer or a stopwatch. Generates the counter's CLR, LOAD/LOAD_EN, EN and DIR from user START/STOP/RESET pulses and a tick prescaler. Watches the counter's BCD value to stop at the terminal count, with no wrap. Sits between the debounced button logic and the counter instance, all on the CLK domain.

Parameters:
TICK_DIV, 4, CLK cycles per count tick; legal values are 2 or more.
PS_W, 2, prescaler width; must satisfy 2^PS_W >= TICK_DIV.

Ports:
CLK  in  1  system clock, rising edge.
CLR_N  in  1  asynchronous active-low reset.
MODE  in  1  1 = stopwatch (count up from 0000); 0 = countdown from PRESET. Sampled only on an accepted START.
START  in  1  single-cycle pulse: start or resume.
STOP  in  1  single-cycle pulse: pause.
RESET  in  1  single-cycle pulse: synchronous soft reset to IDLE.
PRESET  in  16  countdown start value, 4 BCD digits, [15:12] = most significant.
CNT_VAL  in  16  counter OUT bus.
CNT_CLR  out  1  counter clear.
CNT_LOAD  out  16  counter LOAD bus.
CNT_LOAD_EN  out  1  counter load enable.
CNT_EN  out  1  counter count enable, one-cycle pulse per tick.
CNT_DIR  out  1  counter direction (1 = up).
RUNNING  out  1  high in RUN.
DONE  out  1  high in DONE.
ERR  out  1  one-cycle pulse when a START is rejected.

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset (CLR_N low): state INIT, CNT_CLR=1, everything else 0, prescaler PS=0, mode register=0.
- States: INIT, IDLE, ARM, RUN, PAUSE, DONE.
- INIT -> IDLE on the first CLK edge after reset release. CNT_CLR is high for exactly that one cycle.
- Input precedence in every state: RESET > STOP > START.
- RESET, any state: CNT_CLR=1 for one cycle, CNT_EN=0, PS=0, next state IDLE.
- START in IDLE or DONE:
  - Latch MODE into the mode register.
  - CNT_DIR = mode register from the next cycle onward.
  - MODE=1: CNT_CLR=1 for one cycle, next state ARM.
  - MODE=0 with PRESET all-valid BCD (every nibble <= 9) and nonzero: CNT_LOAD=PRESET, CNT_LOAD_EN=1 for one cycle, next state ARM.
  - MODE=0 with PRESET invalid or 0000: ERR=1 for one cycle, state unchanged, counter untouched.
- ARM: one cycle for the load/clear to land. PS=0, next state RUN. STOP or START in ARM is ignored; RESET still applies.
- RUN:
  - PS increments each cycle.
  - When PS==TICK_DIV-1: PS<=0 and CNT_EN=1 on the next cycle.
  - First CNT_EN appears TICK_DIV cycles after entering RUN, then every TICK_DIV cycles.
- Terminal count, checked in RUN only when CNT_EN==0:
  - Terminal value is 0000 when mode=0 and 9999 when mode=1.
  - If CNT_VAL equals the terminal value, next state DONE, PS=0, and no further CNT_EN is issued.
  - The counter never wraps or raises its over/underflow under this controller.
- STOP in RUN -> PAUSE. PS holds its value and any pending tick is cancelled. START in PAUSE -> RUN, PS resumes from the held value.
- START and STOP in the same cycle during RUN -> PAUSE.
- STOP in IDLE or DONE: ignored. STOP in PAUSE: ignored.
- DONE: DONE=1, CNT_VAL holds. START re-arms as from IDLE.
- PRESET and MODE are ignored outside an accepted START.

Test Plan:
1. Release CLR_N -> CNT_CLR=1 for exactly 1 cycle, then IDLE with all outputs 0.
2. MODE=0, PRESET=0x0003, START (TICK_DIV=4) -> CNT_LOAD_EN pulse with LOAD=0x0003. CNT_EN pulses every 4 cycles with DIR=0. CNT_VAL goes 0003->0002->0001->0000. DONE=1 within 2 cycles of reaching 0000 and no 4th EN pulse.
3. MODE=1, START with the counter preloaded to 9997 by forcing CNT_VAL -> exactly 2 EN pulses, then DONE; CNT_VAL stays at 9999 and never reaches 0000.
4. Countdown from 0x0020: STOP after the 3rd tick, hold 10 cycles, then START -> no EN pulses during PAUSE. The next EN comes TICK_DIV minus the elapsed PS cycles after resume.
5. START with PRESET=0x00A5, then with 0x0000 (MODE=0) -> ERR pulse each time, state stays IDLE, CNT_LOAD_EN stays 0.
6. RESET during RUN in the same cycle as START and STOP -> CNT_CLR pulse, IDLE, RUNNING=0, no CNT_EN afterwards.
